// File: rtl/video_timing_gen.sv
// Video timing source: hsync/vsync pulses, data-enable and 8-bit test pattern; VTG_MOVING_RAMP_EN selects the moving diagonal ramp.
// Latency: outputs registered, first o_vs/o_hs one cycle after i_en is sampled in IDLE.
// Backpressure: none; free-running while enabled, always stops on a frame boundary.
module video_timing_gen #(
    parameter int CNT_V_SIZE = 12,
    parameter int CNT_H_SIZE = 12,
    parameter int VBP        = 3,
    parameter int VAC        = 1080,
    parameter int VFP        = 3,
    parameter int HBP        = 3,
    parameter int HAC        = 1920,
    parameter int HFP        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic       o_vs,
    output logic       o_hs,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int HTOT = 1 + HBP + HAC + HFP;
    localparam int VTOT = 1 + VBP + VAC + VFP;

    localparam logic [CNT_H_SIZE-1:0] H_LAST   = CNT_H_SIZE'(HTOT - 1);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_LO = CNT_H_SIZE'(HBP + 1);
    localparam logic [CNT_H_SIZE-1:0] H_ACT_HI = CNT_H_SIZE'(HBP + HAC);
    localparam logic [CNT_V_SIZE-1:0] V_LAST   = CNT_V_SIZE'(VTOT - 1);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_LO = CNT_V_SIZE'(VBP + 1);
    localparam logic [CNT_V_SIZE-1:0] V_ACT_HI = CNT_V_SIZE'(VBP + VAC);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_STOP = 3'b100;

    logic [2:0]            state, state_nxt;
    logic [CNT_H_SIZE-1:0] h, h_nxt;
    logic [CNT_V_SIZE-1:0] v, v_nxt;
    logic                  h_wrap, v_wrap;
    logic [7:0]            frame_cnt, frame_cnt_nxt;

    logic       busy_d, hs_d, vs_d, de_d, fd_d;
    logic [7:0] x8;
`ifdef VTG_MOVING_RAMP_EN
    logic [7:0] y8;
`endif
    logic [7:0] data_d;

    always_comb begin
        h_wrap    = (h == H_LAST);
        v_wrap    = (v == V_LAST);
        state_nxt = state;
        h_nxt     = h;
        v_nxt     = v;
        case (state)
            S_IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (i_en) state_nxt = S_RUN;
            end
            S_RUN, S_STOP: begin
                h_nxt = h_wrap ? '0 : h + CNT_H_SIZE'(1);
                if (h_wrap) v_nxt = v_wrap ? '0 : v + CNT_V_SIZE'(1);
                // i_en only decides the state; the counters never see it mid-frame
                if (h_wrap && v_wrap) state_nxt = i_en ? S_RUN : S_IDLE;
                else                  state_nxt = i_en ? S_RUN : S_STOP;
            end
            default: begin
                state_nxt = S_IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next position so the registers line up with (h,v).
    always_comb begin
        busy_d = (state_nxt != S_IDLE);
        hs_d   = busy_d && (h_nxt == '0);
        vs_d   = hs_d && (v_nxt == '0);
        de_d   = busy_d && (h_nxt >= H_ACT_LO) && (h_nxt <= H_ACT_HI)
                        && (v_nxt >= V_ACT_LO) && (v_nxt <= V_ACT_HI);
        fd_d   = busy_d && (h_nxt == H_LAST) && (v_nxt == V_LAST);
        frame_cnt_nxt = frame_cnt + 8'(o_frame_done);
        x8     = 8'(h_nxt - H_ACT_LO);
`ifdef VTG_MOVING_RAMP_EN
        y8     = 8'(v_nxt - V_ACT_LO);
`endif
        data_d = 8'd0;
        if (de_d) begin
`ifdef VTG_MOVING_RAMP_EN
            data_d = x8 + y8 + frame_cnt_nxt;
`else
            data_d = x8;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            h            <= '0;
            v            <= '0;
            frame_cnt    <= 8'd0;
            o_vs         <= 1'b0;
            o_hs         <= 1'b0;
            o_de         <= 1'b0;
            o_data       <= 8'd0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            h            <= h_nxt;
            v            <= v_nxt;
            frame_cnt    <= frame_cnt_nxt;
            o_vs         <= vs_d;
            o_hs         <= hs_d;
            o_de         <= de_d;
            o_data       <= data_d;
            o_busy       <= busy_d;
            o_frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed frame/stop/reset phases plus random i_en/rst, checked against a frame-position model.
module tb_video_timing_gen;

    localparam int HBP  = 2;
    localparam int HAC  = 4;
    localparam int HFP  = 2;
    localparam int VBP  = 1;
    localparam int VAC  = 3;
    localparam int VFP  = 1;
    localparam int HTOT = 1 + HBP + HAC + HFP;
    localparam int VTOT = 1 + VBP + VAC + VFP;
    localparam int FLEN = HTOT * VTOT;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       i_en = 1'b0;
    logic       o_vs, o_hs, o_de, o_busy, o_frame_done;
    logic [7:0] o_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CNT_V_SIZE(12), .CNT_H_SIZE(12),
        .VBP(VBP), .VAC(VAC), .VFP(VFP),
        .HBP(HBP), .HAC(HAC), .HFP(HFP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .i_en(i_en),
        .o_vs(o_vs),
        .o_hs(o_hs),
        .o_de(o_de),
        .o_data(o_data),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    // Reference: a frame is FLEN cycles indexed by m_pos; stopping is only honoured at the last cycle.
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_fcnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_pos  <= 0;
            m_fcnt <= 0;
        end else if (!m_run) begin
            if (i_en) begin
                m_run <= 1'b1;
                m_pos <= 0;
            end
        end else if (m_pos == FLEN - 1) begin
            m_fcnt <= (m_fcnt + 1) % 256;
            m_pos  <= 0;
            if (!i_en) m_run <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d (pos=%0d run=%0d)",
                     tag, $time, obs, exp, m_pos, m_run);
        end
    endtask

    task automatic compare_outputs();
        int  h, v, e_data;
        bit  act;
        h   = m_pos % HTOT;
        v   = m_pos / HTOT;
        act = m_run && h >= HBP + 1 && h <= HBP + HAC && v >= VBP + 1 && v <= VBP + VAC;
`ifdef VTG_MOVING_RAMP_EN
        e_data = act ? ((h - HBP - 1) + (v - VBP - 1) + m_fcnt) % 256 : 0;
`else
        e_data = act ? (h - HBP - 1) % 256 : 0;
`endif
        check("vs",   32'(o_vs),         32'(m_run && m_pos == 0));
        check("hs",   32'(o_hs),         32'(m_run && h == 0));
        check("de",   32'(o_de),         32'(act));
        check("data", 32'(o_data),       32'(e_data));
        check("busy", 32'(o_busy),       32'(m_run));
        check("fdone",32'(o_frame_done), 32'(m_run && m_pos == FLEN - 1));
    endtask

    // Check the current cycle, then drive inputs to be sampled on the next edge.
    task automatic step(input logic nrst, input logic nen);
        @(negedge clk);
        compare_outputs();
        rst  = nrst;
        i_en = nen;
    endtask

    initial begin
        logic en_r;
        int   r;
        repeat (3) step(1'b1, 1'b0);
        // continuous frames
        repeat (2 * FLEN + 1) step(1'b0, 1'b1);
        // drop mid-frame, frame must complete, then idle
        repeat (10) step(1'b0, 1'b1);
        repeat (100) step(1'b0, 1'b0);
        // drop and re-raise within a frame: no gap
        repeat (10) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        repeat (2 * FLEN) step(1'b0, 1'b1);
        // reset mid-frame with i_en held
        repeat (30) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (FLEN + 5) step(1'b0, 1'b1);
        // reset then stay idle
        repeat (20) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        // random i_en toggling with occasional reset
        en_r = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 40) en_r = ($urandom_range(0, 99) < 70);
            step(r == 999, en_r);
        end
        // long run to wrap the frame counter
        step(1'b1, 1'b1);
        repeat (FLEN * 260) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream source for the 3x3 image filter control FSM.
- Generates the single-cycle vsync/hsync pulses, the data-enable and an 8-bit test-pattern pixel stream, with porch timing that matches what the filter FSM counts.
- Runs frames continuously while enabled and always stops on a frame boundary.

Parameters:
CNT_V_SIZE, 12, vertical counter width; must hold VTOT-1
CNT_H_SIZE, 12, horizontal counter width; must hold HTOT-1
VBP, 3, back-porch lines after the sync line
VAC, 1080, active lines
VFP, 3, front-porch lines
HBP, 3, back-porch cycles after the hsync cycle
HAC, 1920, active pixels per line
HFP, 3, front-porch cycles

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
i_en  in  1  run request; level-sensitive
o_vs  out  1  frame-start pulse, one cycle
o_hs  out  1  line-start pulse, one cycle
o_de  out  1  active pixel valid
o_data  out  8  pixel value; 0 when o_de=0
o_busy  out  1  frame in progress
o_frame_done  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- One clock. Reset is synchronous and active-high: clock and reset are named clk and rst.
- Reset: state=IDLE; h=v=0; every output=0, including the frame counter.
- Derived constants: HTOT=1+HBP+HAC+HFP; VTOT=1+VBP+VAC+VFP.
- Horizontal position h:
  - h=0: hsync cycle.
  - h=1..HBP: back porch.
  - h=HBP+1..HBP+HAC: active.
  - Remainder: front porch.
- Vertical position v:
  - v=0: sync line.
  - v=1..VBP: back porch.
  - v=VBP+1..VBP+VAC: active.
  - Remainder: front porch.
- Counting: h increments every cycle in RUN/STOP and wraps at HTOT-1. v increments on the h wrap and wraps at VTOT-1.
- All outputs are registered and reflect the current (h,v):
  - o_hs = (h==0).
  - o_vs = (h==0 && v==0), so it is coincident with that line's o_hs.
  - o_de = active h AND active v.
  - o_frame_done = (h==HTOT-1 && v==VTOT-1).
  - o_busy = state != IDLE.
- Pixel coordinates: x = h-(HBP+1) and y = v-(VBP+1) during active; widths as the counters.
- o_data = x[7:0] when o_de=1, else 0 (before the optional feature below).
- State machine (one-hot, 3 states):
  - IDLE: if i_en, go to RUN with h=v=0. o_vs/o_hs assert on the cycle immediately after the edge that sampled i_en=1.
  - RUN: if i_en=0, go to STOP (stop pending). At the frame wrap with i_en=1, start the next frame seamlessly, with no gap cycle.
  - STOP: i_en re-asserted returns to RUN with no timing disturbance. At the frame wrap (o_frame_done cycle) go to IDLE with h=v=0.
- Stopping never truncates a frame: a full VTOT*HTOT cycles elapse from o_vs to o_frame_done.
- i_en toggling mid-frame never alters h, v, o_vs, o_hs, o_de or o_data.
- rst mid-frame: all outputs are 0 on the next cycle; no further pulses until i_en is sampled high in IDLE.
- The frame counter (8 bit) increments on o_frame_done and wraps 255 to 0; it resets only on rst.
- In IDLE all outputs are held at 0.

Optional Feature:
- Macro: VTG_MOVING_RAMP_EN.
- Defined: o_data = (x[7:0] + y[7:0] + frame_cnt[7:0]) mod 256 during o_de, giving a diagonal ramp that shifts by 1 per frame.
- Undefined: o_data = x[7:0] during o_de. The frame counter is still present and drives nothing externally.
- Timing and all other outputs are identical in both builds.

Test Plan:
All scenarios use HBP=2, HAC=4, HFP=2, VBP=1, VAC=3, VFP=1, giving HTOT=9, VTOT=6, 54 cycles per frame.
1. rst=1 for 3 cycles, then i_en=1 -> all outputs 0 during reset; o_vs=o_hs=1 on the cycle after i_en is sampled, then o_hs every 9 cycles and o_vs every 54 cycles.
2. Single frame, i_en held -> o_de high for 4 consecutive cycles at h=3..6 on v=2..4 only (12 active cycles per frame); o_data=0,1,2,3 on each active line (macro off).
3. i_en dropped at cycle 10 of frame -> frame completes; o_frame_done at cycle 53; o_busy=0 from cycle 54; no o_vs afterwards.
4. i_en low at cycle 10, high again at cycle 20 -> back-to-back frames with no gap; second o_vs at cycle 54.
5. rst pulsed at cycle 30 mid-frame -> all outputs 0 on cycle 31; o_vs reappears exactly 1 cycle after i_en is next sampled high.
6. VTG_MOVING_RAMP_EN defined, 3 frames -> first active pixel of frame k (k=0,1,2) is k; last active pixel of frame 0 is 3+2=5.
